// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory plus byte-stream loader that sits
// in front of the Mips32 core.
//
// A program image arrives as a ready/valid byte stream and is packed
// little-endian into 32-bit words. The core fetches combinationally through
// raddr -> instr and is held in reset until the byte flagged by in_last has
// been accepted.
//
// Ports:
//   clock       single clock, all state updates on posedge
//   reset       synchronous, active-high
//   in_valid    byte-stream valid
//   in_data     image byte
//   in_last     final byte of the image (qualified by in_valid)
//   in_ready    loader can accept a byte (LOAD state and not in reset)
//   raddr       word address from the core (pc >> 2)
//   instr       fetched instruction, or 32'h0000000D (break) when masked
//   core_reset  drives the core's reset; released once the image is loaded
//   load_done   image complete
//   word_count  number of words written, saturates at 2**ADDR_SIZE
//   overflow    sticky: a byte arrived while storage was already full
module imem_loader #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  input  logic [31:0]          raddr,
  output logic [31:0]          instr,
  output logic                 core_reset,
  output logic                 load_done,
  output logic [ADDR_SIZE:0]   word_count,
  output logic                 overflow
);

  localparam int                 DEPTH    = 2 ** ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] FULL_CNT = (ADDR_SIZE + 1)'(DEPTH);
  localparam logic [31:0]        BREAK    = 32'h0000_000D;

  typedef enum logic {LOAD, DONE} state_t;

  state_t      state;
  logic [1:0]  byte_idx;
  logic [31:0] asm_word;
  logic [31:0] mem [DEPTH];

  logic        accept;
  logic        full;
  logic        word_wr;
  logic [31:0] word_next;

  assign in_ready = (state == LOAD) && !reset;
  assign accept   = in_valid && in_ready;
  assign full     = (word_count == FULL_CNT);

  // The assembly register is cleared after every word, so the bytes above
  // the current index are already zero; this gives the zero-filled partial
  // word on in_last for free.
  always_comb begin
    word_next = asm_word;
    word_next[8*byte_idx +: 8] = in_data;
  end

  // A word is committed on its 4th byte or on the last byte of the image,
  // whichever comes first; both at once still commit exactly one word.
  assign word_wr = accept && !full && ((byte_idx == 2'd3) || in_last);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= LOAD;
      byte_idx   <= 2'd0;
      asm_word   <= 32'd0;
      word_count <= '0;
      overflow   <= 1'b0;
      load_done  <= 1'b0;
      core_reset <= 1'b1;
    end else if (accept) begin
      if (full) begin
        // Storage is full: the byte is swallowed and only flagged.
        overflow <= 1'b1;
      end else if (word_wr) begin
        byte_idx   <= 2'd0;
        asm_word   <= 32'd0;
        word_count <= word_count + 1'b1;
      end else begin
        byte_idx <= byte_idx + 2'd1;
        asm_word <= word_next;
      end
      if (in_last) begin
        state      <= DONE;
        load_done  <= 1'b1;
        core_reset <= 1'b0;
      end
    end
  end

  // Storage is deliberately not reset; stale contents are masked by word_count.
  always_ff @(posedge clock) begin
    if (word_wr) begin
      mem[word_count[ADDR_SIZE-1:0]] <= word_next;
    end
  end

  // Fetch only inside the loaded image; anything else reads as break so a
  // runaway PC halts the core.
  always_comb begin
    instr = BREAK;
    if (load_done && (raddr[31:ADDR_SIZE] == '0) &&
        ({1'b0, raddr[ADDR_SIZE-1:0]} < word_count)) begin
      instr = mem[raddr[ADDR_SIZE-1:0]];
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  // Instance A: default depth (256 words)
  logic        in_valid = 1'b0;
  logic [7:0]  in_data  = 8'h00;
  logic        in_last  = 1'b0;
  logic        in_ready;
  logic [31:0] raddr    = 32'd0;
  logic [31:0] instr;
  logic        core_reset;
  logic        load_done;
  logic [8:0]  word_count;
  logic        overflow;

  // Instance B: 4-word storage for the overflow case
  logic        in_valid2 = 1'b0;
  logic [7:0]  in_data2  = 8'h00;
  logic        in_last2  = 1'b0;
  logic        in_ready2;
  logic [31:0] raddr2    = 32'd0;
  logic [31:0] instr2;
  logic        core_reset2;
  logic        load_done2;
  logic [2:0]  word_count2;
  logic        overflow2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  imem_loader #(.ADDR_SIZE(8)) u_dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .raddr(raddr), .instr(instr),
    .core_reset(core_reset), .load_done(load_done),
    .word_count(word_count), .overflow(overflow)
  );

  imem_loader #(.ADDR_SIZE(2)) u_dut_small (
    .clock(clock), .reset(reset),
    .in_valid(in_valid2), .in_data(in_data2), .in_last(in_last2), .in_ready(in_ready2),
    .raddr(raddr2), .instr(instr2),
    .core_reset(core_reset2), .load_done(load_done2),
    .word_count(word_count2), .overflow(overflow2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Present one byte at a negedge; it is accepted on the following posedge.
  task automatic send_a(input logic [7:0] d, input logic last);
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d, input logic last);
    @(negedge clock);
    in_valid2 = 1'b1;
    in_data2  = d;
    in_last2  = last;
    @(posedge clock);
    #1;
    in_valid2 = 1'b0;
    in_last2  = 1'b0;
  endtask

  task automatic fetch_a(input string tag, input logic [31:0] a, input logic [31:0] exp);
    raddr = a;
    #1;
    check(tag, instr, exp);
  endtask

  task automatic fetch_b(input string tag, input logic [31:0] a, input logic [31:0] exp);
    raddr2 = a;
    #1;
    check(tag, instr2, exp);
  endtask

  logic [7:0] img1 [8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
  logic [7:0] img2 [6] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
  logic [7:0] prog [12] = '{8'h00, 8'h00, 8'h01, 8'h20,   // 0x20010000
                            8'h0A, 8'h00, 8'h02, 8'h20,   // 0x2002000A
                            8'h20, 8'h18, 8'h22, 8'h00};  // 0x00221820

  initial begin
    // Reset state
    do_reset();
    #1;
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    fetch_a("load_fetch_masked", 32'd0, 32'h0000000D);

    // Two full words, in_last on the 8th byte
    for (int i = 0; i < 7; i++) send_a(img1[i], 1'b0);
    @(negedge clock);
    in_valid = 1'b1; in_data = img1[7]; in_last = 1'b1;
    #1;
    check("pre_last_load_done", 32'(load_done), 32'd0);
    check("pre_last_core_reset", 32'(core_reset), 32'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    check("last_load_done", 32'(load_done), 32'd1);
    check("last_core_reset", 32'(core_reset), 32'd0);
    check("img1_word_count", 32'(word_count), 32'd2);
    check("done_in_ready", 32'(in_ready), 32'd0);
    fetch_a("img1_w0", 32'd0, 32'h12345678);
    fetch_a("img1_w1", 32'd1, 32'hDEADBEEF);
    fetch_a("img1_mask_cnt", 32'd2, 32'h0000000D);
    fetch_a("img1_mask_hi", 32'h100, 32'h0000000D);

    // in_valid pulses in DONE are ignored
    for (int i = 0; i < 3; i++) send_a(8'h55, i == 2);
    check("done_pulse_count", 32'(word_count), 32'd2);
    fetch_a("done_pulse_w1", 32'd1, 32'hDEADBEEF);

    // Same image with random idle gaps
    do_reset();
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      send_a(img1[i], i == 7);
    end
    check("gap_word_count", 32'(word_count), 32'd2);
    check("gap_load_done", 32'(load_done), 32'd1);
    fetch_a("gap_w0", 32'd0, 32'h12345678);
    fetch_a("gap_w1", 32'd1, 32'hDEADBEEF);

    // Partial final word is zero-filled
    do_reset();
    for (int i = 0; i < 6; i++) send_a(img2[i], i == 5);
    check("part_word_count", 32'(word_count), 32'd2);
    fetch_a("part_w0", 32'd0, 32'hDDCCBBAA);
    fetch_a("part_w1", 32'd1, 32'h00002211);
    fetch_a("part_mask", 32'd2, 32'h0000000D);

    // in_last on the 4th byte writes exactly one word
    do_reset();
    for (int i = 0; i < 4; i++) send_a(img1[i], i == 3);
    check("last4_word_count", 32'(word_count), 32'd1);
    fetch_a("last4_w0", 32'd0, 32'h12345678);
    fetch_a("last4_no_pad", 32'd1, 32'h0000000D);

    // Reset mid-load drops partial data
    do_reset();
    for (int i = 0; i < 5; i++) send_a(img2[i], 1'b0);
    check("mid_count_before", 32'(word_count), 32'd1);
    do_reset();
    #1;
    check("mid_word_count", 32'(word_count), 32'd0);
    check("mid_core_reset", 32'(core_reset), 32'd1);
    check("mid_in_ready", 32'(in_ready), 32'd1);
    fetch_a("mid_stale_masked", 32'd0, 32'h0000000D);

    // Reset coincident with a valid byte: reset wins
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b1; in_data = 8'h99; in_last = 1'b1;
    #1;
    check("rst_coinc_ready", 32'(in_ready), 32'd0);
    @(negedge clock);
    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    #1;
    check("rst_coinc_count", 32'(word_count), 32'd0);
    check("rst_coinc_done", 32'(load_done), 32'd0);

    // Reload a program image from word 0
    for (int i = 0; i < 12; i++) send_a(prog[i], i == 11);
    check("prog_word_count", 32'(word_count), 32'd3);
    check("prog_core_reset", 32'(core_reset), 32'd0);
    fetch_a("prog_w0", 32'd0, 32'h20010000);
    fetch_a("prog_w1", 32'd1, 32'h2002000A);
    fetch_a("prog_w2", 32'd2, 32'h00221820);
    fetch_a("prog_w3", 32'd3, 32'h0000000D);

    // Overflow on the 4-word instance: 20 bytes 0x00..0x13
    do_reset();
    for (int i = 0; i < 16; i++) send_b(8'(i), 1'b0);
    check("ovf_full_count", 32'(word_count2), 32'd4);
    check("ovf_not_yet", 32'(overflow2), 32'd0);
    check("ovf_ready_full", 32'(in_ready2), 32'd1);
    for (int i = 16; i < 20; i++) send_b(8'(i), i == 19);
    check("ovf_word_count", 32'(word_count2), 32'd4);
    check("ovf_flag", 32'(overflow2), 32'd1);
    check("ovf_load_done", 32'(load_done2), 32'd1);
    fetch_b("ovf_w0", 32'd0, 32'h03020100);
    fetch_b("ovf_w1", 32'd1, 32'h07060504);
    fetch_b("ovf_w2", 32'd2, 32'h0B0A0908);
    fetch_b("ovf_w3", 32'd3, 32'h0F0E0D0C);
    fetch_b("ovf_mask_hi", 32'd4, 32'h0000000D);
    do_reset();
    #1;
    check("ovf_cleared", 32'(overflow2), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
